// File: rtl/eth_rx_dst_filter.sv
// Destination-MAC frame filter for the RGMII RX byte stream, with saturating statistics.
// Optional promiscuous input when ETH_RX_DST_FILTER_PROMISC_EN is defined.
module eth_rx_dst_filter #(
    parameter bit ACCEPT_BROADCAST = 1'b1,
    parameter bit ACCEPT_MULTICAST = 1'b0,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [47:0]          local_mac,
`ifdef ETH_RX_DST_FILTER_PROMISC_EN
    input  logic                 promisc,
`endif
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic [CNT_WIDTH-1:0] frames_accepted,
    output logic [CNT_WIDTH-1:0] frames_dropped
);

    typedef enum logic [1:0] {HDR, REPLAY, PASS, DROP} state_t;

    state_t      state;
    logic [7:0]  hdr_buf [6];
    logic [2:0]  idx;
    logic [47:0] dst;
    logic        promisc_on;
    logic        match;
    logic        s_fire;

`ifdef ETH_RX_DST_FILTER_PROMISC_EN
    assign promisc_on = promisc;
`else
    assign promisc_on = 1'b0;
`endif

    // The 6th byte is still on the bus at the decision edge.
    assign dst = {hdr_buf[0], hdr_buf[1], hdr_buf[2],
                  hdr_buf[3], hdr_buf[4], s_axis_tdata};

    assign match = (dst == local_mac)
                || (ACCEPT_BROADCAST && dst == 48'hFFFF_FFFF_FFFF)
                || (ACCEPT_MULTICAST && dst[40])
                || promisc_on;

    assign s_fire = s_axis_tvalid && s_axis_tready;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        unique case (state)
            HDR: s_axis_tready = !rst;
            REPLAY: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_buf[idx];
            end
            PASS: begin
                s_axis_tready = m_axis_tready && !rst;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = s_axis_tuser;
            end
            DROP: s_axis_tready = !rst;
            default: s_axis_tready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= HDR;
            idx             <= 3'd0;
            frames_accepted <= '0;
            frames_dropped  <= '0;
            for (int i = 0; i < 6; i++) hdr_buf[i] <= 8'h00;
        end else begin
            unique case (state)
                HDR: if (s_fire) begin
                    if (s_axis_tlast) begin
                        frames_dropped <= sat_inc(frames_dropped);
                        idx            <= 3'd0;
                    end else begin
                        hdr_buf[idx] <= s_axis_tdata;
                        if (idx == 3'd5) begin
                            idx   <= 3'd0;
                            state <= match ? REPLAY : DROP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                REPLAY: if (m_axis_tready) begin
                    if (idx == 3'd5) begin
                        idx   <= 3'd0;
                        state <= PASS;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                PASS: if (s_fire && s_axis_tlast) begin
                    frames_accepted <= sat_inc(frames_accepted);
                    idx             <= 3'd0;
                    state           <= HDR;
                end
                DROP: if (s_fire && s_axis_tlast) begin
                    frames_dropped <= sat_inc(frames_dropped);
                    idx            <= 3'd0;
                    state          <= HDR;
                end
                default: state <= HDR;
            endcase
        end
    end

endmodule
